ccip_outstanding_req_tracker: RTL
=================================

Name: ccip_outstanding_req_tracker

Overview:
- Passive monitor on one CCI-P port.
- Snoops the AFU-to-FIU request channels c0Tx/c1Tx and the FIU-to-AFU response channels c0Rx/c1Rx.
- Keeps running counts of outstanding read lines, write lines and write fences.
- From those counts it produces registered throttle hints, an idle flag, and sticky protocol-error flags.
- Placed beside an MPF shim or AFU, so that logic can use the hints in place of ad-hoc per-module counters.

Parameters:
- CNT_WIDTH, 12: width of each outstanding counter. Counters saturate at 2^CNT_WIDTH-1.
- RD_THRESH, 448: c0_throttle asserts when outstanding read lines >= RD_THRESH.
- WR_THRESH, 224: c1_throttle asserts when outstanding write lines >= WR_THRESH.
- FENCE_CNT_WIDTH, 4: width of the outstanding-fence counter.

Ports:
- clk  in  1  port clock.
- reset_n  in  1  asynchronous active-low reset.
- c0Tx  in  t_if_ccip_c0_Tx  read request channel (snooped).
- c1Tx  in  t_if_ccip_c1_Tx  write/fence request channel (snooped).
- c0Rx  in  t_if_ccip_c0_Rx  read response / MMIO channel (snooped).
- c1Rx  in  t_if_ccip_c1_Rx  write response channel (snooped).
- clear_err  in  1  synchronous clear of the sticky error flags.
- rd_lines_out  out  CNT_WIDTH  outstanding read lines.
- wr_lines_out  out  CNT_WIDTH  outstanding write lines.
- fences_out  out  FENCE_CNT_WIDTH  outstanding write fences.
- c0_throttle  out  1  read throttle hint.
- c1_throttle  out  1  write throttle hint.
- idle  out  1  no outstanding read, write or fence.
- err_underflow  out  1  sticky: a response arrived with no matching outstanding request.
- err_overflow  out  1  sticky: a counter saturated.

Behaviour:
- Reset: asynchronous on reset_n low. All counters = 0, c0_throttle = 0, c1_throttle = 0, idle = 1, both error flags = 0. Reset mid-traffic discards all counts; responses arriving after reset for pre-reset requests flag err_underflow.
- Every output is a register. Any event is visible on the outputs exactly one clk after the cycle in which it is sampled.
- Read issue: c0Tx.valid adds hdr.cl_len+1 lines (1, 2 or 4).
- Read completion: ccip_c0Rx_isReadRsp subtracts 1. Each response beat is one line. MMIO rd/wr valids are ignored.
- Write issue: c1Tx.valid with req_type one of eREQ_WRLINE_I, eREQ_WRLINE_M or eREQ_WRPUSH_I adds 1 per beat. The sop bit is irrelevant to the count.
- Fence issue: c1Tx.valid with req_type eREQ_WRFENCE increments the fence counter only.
- Write completion: ccip_c1Rx_isWriteRsp subtracts hdr.cl_num+1 when hdr.format = 1 (packed), else subtracts 1.
- Fence completion: ccip_c1Rx_isWriteFenceRsp decrements the fence counter.
- Other c1Tx request types (e.g. interrupts) are ignored.
- Simultaneous issue and completion on the same counter in one cycle: next = cur + inc - dec, computed at CNT_WIDTH+2 bits.
- If the result < 0: counter loads 0 and err_underflow sets.
- If the result > max: counter loads max and err_overflow sets.
- Fence counter follows the same saturate/flag rules.
- Throttles: c0_throttle = (next rd count >= RD_THRESH); c1_throttle = (next wr count >= WR_THRESH). Both registered alongside the counters.
- idle = all three next counts == 0, registered.
- clear_err: clears both error flags next cycle. If a new error occurs in the same cycle, the new error wins and the flag stays 1.
- No backpressure: the block never stalls or modifies any channel.

Test Plan:
- Reset values: hold reset_n low, then release → counters 0, idle = 1, throttles 0, errors 0. Assert reset_n mid-count → outputs go to reset values immediately (asynchronous).
- Multi-line read: one c0Tx with cl_len = 3 (4 lines) → rd_lines_out = 4 next cycle; 4 read responses on consecutive cycles → 3, 2, 1, 0; idle returns to 1 the cycle after the last response.
- Simultaneous read events: c0Tx cl_len = 1 in the same cycle as one read response, with rd count = 5 → rd count = 6.
- Packed write completion: 3 WRLINE_I beats → wr = 3. Packed write response with format = 1, cl_num = 1 → wr = 1. Unpacked write response → wr = 0.
- Fence, interrupt and underflow: fence issue → fences_out = 1, idle = 0; fence response → 0. c1Tx interrupt request → no count change. Read response with rd = 0 → rd stays 0, err_underflow = 1; clear_err → 0.
- Throttle and saturation: RD_THRESH = 8; issue 2×cl_len = 3 reads → c0_throttle = 1 at count 8. With CNT_WIDTH = 3, issue 9 lines → counter holds 7, err_overflow = 1.

Source files
------------

// File: rtl/ccip_outstanding_req_tracker.sv
// Outstanding-request tracker for one CCI-P port. It only watches the request
// and response channels and keeps registered counts of read lines, write lines
// and write fences. Throttle hints, an idle flag and sticky error flags are
// derived from those counts.

// Minimal CCI-P channel types and response classifiers used by the tracker.
package ccip_if_pkg;
  typedef logic [1:0]   t_ccip_vc;
  typedef logic [1:0]   t_ccip_clLen;
  typedef logic [1:0]   t_ccip_clNum;
  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [15:0]  t_ccip_mdata;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]   rsvd2;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    t_ccip_clNum  cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic         format;
    logic         rsvd0;
    t_ccip_clNum  cl_num;
    t_ccip_c1_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c1_RspMemHdr hdr;
    logic               rspValid;
  } t_if_ccip_c1_Rx;

  function automatic logic ccip_c0Rx_isReadRsp(input t_if_ccip_c0_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_RDLINE);
  endfunction

  function automatic logic ccip_c1Rx_isWriteRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_WRLINE);
  endfunction

  function automatic logic ccip_c1Rx_isWriteFenceRsp(input t_if_ccip_c1_Rx rx);
    return rx.rspValid && (rx.hdr.resp_type == eRSP_WRFENCE);
  endfunction
endpackage

module ccip_outstanding_req_tracker
  import ccip_if_pkg::*;
#(
  parameter int unsigned CNT_WIDTH       = 12,
  parameter int unsigned RD_THRESH       = 448,
  parameter int unsigned WR_THRESH       = 224,
  parameter int unsigned FENCE_CNT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  t_if_ccip_c0_Tx             c0Tx,
  input  t_if_ccip_c1_Tx             c1Tx,
  input  t_if_ccip_c0_Rx             c0Rx,
  input  t_if_ccip_c1_Rx             c1Rx,
  input  logic                       clear_err,
  output logic [CNT_WIDTH-1:0]       rd_lines_out,
  output logic [CNT_WIDTH-1:0]       wr_lines_out,
  output logic [FENCE_CNT_WIDTH-1:0] fences_out,
  output logic                       c0_throttle,
  output logic                       c1_throttle,
  output logic                       idle,
  output logic                       err_underflow,
  output logic                       err_overflow
);

  // Two guard bits: top bit marks a negative result, next bit marks above max.
  localparam int unsigned CW = CNT_WIDTH + 2;
  localparam int unsigned FW = FENCE_CNT_WIDTH + 2;

  logic [2:0]                 rd_inc;
  logic                       rd_dec;
  logic                       wr_inc;
  logic [2:0]                 wr_dec;
  logic                       fn_inc;
  logic                       fn_dec;
  logic [CW-1:0]              rd_sum;
  logic [CW-1:0]              wr_sum;
  logic [FW-1:0]              fn_sum;
  logic [CNT_WIDTH-1:0]       rd_next;
  logic [CNT_WIDTH-1:0]       wr_next;
  logic [FENCE_CNT_WIDTH-1:0] fn_next;
  logic                       any_under;
  logic                       any_over;
  logic                       unused_fields;

  // Header fields the tracker has no use for (addresses, data, mdata, ...).
  assign unused_fields = ^{c0Tx, c1Tx, c0Rx, c1Rx};

  // Decode snooped channel traffic into per-counter increments and decrements.
  always_comb begin
    rd_inc = 3'd0;
    wr_inc = 1'b0;
    wr_dec = 3'd0;
    fn_inc = 1'b0;
    if (c0Tx.valid) rd_inc = {1'b0, c0Tx.hdr.cl_len} + 3'd1;
    rd_dec = ccip_c0Rx_isReadRsp(c0Rx);
    if (c1Tx.valid) begin
      case (c1Tx.hdr.req_type)
        eREQ_WRLINE_I, eREQ_WRLINE_M, eREQ_WRPUSH_I: wr_inc = 1'b1;
        eREQ_WRFENCE:                                fn_inc = 1'b1;
        default:                                     ;
      endcase
    end
    if (ccip_c1Rx_isWriteRsp(c1Rx))
      wr_dec = c1Rx.hdr.format ? ({1'b0, c1Rx.hdr.cl_num} + 3'd1) : 3'd1;
    fn_dec = ccip_c1Rx_isWriteFenceRsp(c1Rx);
  end

  // Combine issue and completion in one step, then clamp to [0, max].
  always_comb begin
    rd_sum = {2'b00, rd_lines_out} + CW'(rd_inc) - CW'(rd_dec);
    wr_sum = {2'b00, wr_lines_out} + CW'(wr_inc) - CW'(wr_dec);
    fn_sum = {2'b00, fences_out} + FW'(fn_inc) - FW'(fn_dec);

    any_under = rd_sum[CW-1] | wr_sum[CW-1] | fn_sum[FW-1];
    any_over  = (~rd_sum[CW-1] & rd_sum[CW-2]) |
                (~wr_sum[CW-1] & wr_sum[CW-2]) |
                (~fn_sum[FW-1] & fn_sum[FW-2]);

    rd_next = rd_sum[CW-1] ? '0 : (rd_sum[CW-2] ? '1 : rd_sum[CNT_WIDTH-1:0]);
    wr_next = wr_sum[CW-1] ? '0 : (wr_sum[CW-2] ? '1 : wr_sum[CNT_WIDTH-1:0]);
    fn_next = fn_sum[FW-1] ? '0 : (fn_sum[FW-2] ? '1 : fn_sum[FENCE_CNT_WIDTH-1:0]);
  end

  // Register counts and derived hints; a fresh error outranks clear_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_lines_out  <= '0;
      wr_lines_out  <= '0;
      fences_out    <= '0;
      c0_throttle   <= 1'b0;
      c1_throttle   <= 1'b0;
      idle          <= 1'b1;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
    end else begin
      rd_lines_out  <= rd_next;
      wr_lines_out  <= wr_next;
      fences_out    <= fn_next;
      c0_throttle   <= (32'(rd_next) >= RD_THRESH);
      c1_throttle   <= (32'(wr_next) >= WR_THRESH);
      idle          <= (rd_next == '0) && (wr_next == '0) && (fn_next == '0);
      err_underflow <= any_under | (err_underflow & ~clear_err);
      err_overflow  <= any_over  | (err_overflow  & ~clear_err);
    end
  end

endmodule
